shift_lane_arbiter: RTL and testbench

Round-robin arbiter that shares one serial shift-register viewer between several serial bit-stream lanes. It grants one lane at a time for exactly one `WIDTH`-bit word and forwards that lane's bits as a registered `data`/`data_val` pair. The downstream viewer therefore always sees whole, word-aligned captures from a single source. It sits between the lane sources (PRBS checkers, deserializer taps) and a single shift-register viewer instance.

---
 rtl/shift_arb_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/shift_lane_arbiter.sv | 166 ++++++++++++++++
 tb/tb_shift_lane_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared types and helpers for shift_lane_arbiter
package shift_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } shift_arb_state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker, scans upward from last+1
module rr_priority_picker
  import shift_arb_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]                   req_i,
  input  logic [idx_width(NUM_LANES)-1:0]        last_i,
  output logic [NUM_LANES-1:0]                   gnt_o,
  output logic [idx_width(NUM_LANES)-1:0]        idx_o,
  output logic                                   any_o
);

  localparam int IW = idx_width(NUM_LANES);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    // k = NUM_LANES wraps back to last itself, so it is the lowest priority
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = IW'((int'(last_i) + k) % NUM_LANES);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/shift_lane_arbiter.sv
// rtl/shift_lane_arbiter.sv - grants one serial lane per WIDTH-bit word to a shared viewer
// Optional watchdog abort enabled by defining SHIFT_ARB_TIMEOUT_EN.
module shift_lane_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LANES-1:0]              req_i,
  input  logic [NUM_LANES-1:0]              data_i,
  input  logic [NUM_LANES-1:0]              data_val_i,
  output logic [NUM_LANES-1:0]              gnt_o,
  output logic [idx_width(NUM_LANES)-1:0]   gnt_idx_o,
  output logic                              data_o,
  output logic                              data_val_o,
  output logic                              word_done_o,
  output logic                              abort_o,
  output logic                              busy_o
);

  localparam int IW = idx_width(NUM_LANES);
  localparam int CW = $clog2(WIDTH + 1);

  if (NUM_LANES < 2 || NUM_LANES > 16 || WIDTH < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("shift_lane_arbiter: illegal parameter value");
  end

  shift_arb_state_t       state_q, state_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_LANES-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   dval_q, dval_d;
  logic                   done_q, done_d;

  logic [NUM_LANES-1:0]   pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;
  logic                   lane_vld;
  logic                   lane_bit;

`ifdef SHIFT_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0]          wd_q, wd_d;
  logic                   abort_q, abort_d;
`endif

  rr_priority_picker #(
    .NUM_LANES (NUM_LANES)
  ) u_picker (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign lane_vld = data_val_i[idx_q];
  assign lane_bit = data_i[idx_q];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    data_d  = 1'b0;
    dval_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SHIFT_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    abort_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          idx_d   = pick_idx;
          gnt_d   = pick_gnt;
          cnt_d   = '0;
`ifdef SHIFT_ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      ST_GRANT: begin
        data_d = lane_bit;
        dval_d = lane_vld;
        // a valid bit always takes precedence over a watchdog expiry
        if (lane_vld) begin
          cnt_d = cnt_q + 1'b1;
`ifdef SHIFT_ARB_TIMEOUT_EN
          wd_d  = '0;
`endif
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            last_d  = idx_q;
            done_d  = 1'b1;
          end
        end
`ifdef SHIFT_ARB_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = idx_q;
          abort_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NUM_LANES - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_ARB_TIMEOUT_EN
      wd_q    <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dval_q  <= dval_d;
      done_q  <= done_d;
`ifdef SHIFT_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      abort_q <= abort_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign data_o      = data_q;
  assign data_val_o  = dval_q;
  assign word_done_o = done_q;
  assign busy_o      = (state_q == ST_GRANT);
`ifdef SHIFT_ARB_TIMEOUT_EN
  assign abort_o     = abort_q;
`else
  assign abort_o     = 1'b0;
`endif

endmodule

// File: tb/tb_shift_lane_arbiter.sv
// tb/tb_shift_lane_arbiter.sv - directed self-checking bench for shift_lane_arbiter
module tb_shift_lane_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] data_i = '0;
  logic [N-1:0] data_val_i = '0;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_idx_o;
  logic         data_o, data_val_o, word_done_o, abort_o, busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_lane_arbiter #(
    .NUM_LANES (N),
    .WIDTH     (W),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .data_val_i  (data_val_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .data_o      (data_o),
    .data_val_o  (data_val_o),
    .word_done_o (word_done_o),
    .abort_o     (abort_o),
    .busy_o      (busy_o)
  );

  task automatic do_reset();
    rst        = 1'b1;
    req_i      = '0;
    data_i     = '0;
    data_val_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_i      = '0;
    data_i     = '0;
    data_val_i = '0;
    @(negedge clk);
    checks++;
    if ({gnt_o, gnt_idx_o, data_o, data_val_o, word_done_o, abort_o, busy_o} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {gnt_o, gnt_idx_o, data_o, data_val_o, word_done_o, abort_o, busy_o});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_no_req gnt=%b busy=%b exp gnt=0000 busy=0", gnt_o, busy_o);
    end
  endtask

  task automatic test_single();
    logic [31:0] word;
    logic [31:0] cap;
    int          pulses;
    word   = 32'hDEADBEEF;
    cap    = '0;
    pulses = 0;
    do_reset();
    req_i = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0001 || busy_o !== 1'b1 || gnt_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL single_grant gnt=%b busy=%b idx=%0d exp gnt=0001 busy=1 idx=0", gnt_o, busy_o, gnt_idx_o);
    end
    for (int i = 0; i < 32; i++) begin
      data_i[0]     = word[31-i];
      data_val_i[0] = 1'b1;
      @(negedge clk);
      if (data_val_o === 1'b1) begin
        pulses++;
        cap = {cap[30:0], data_o};
      end
      if (i < 31) begin
        checks++;
        if (word_done_o !== 1'b0 || gnt_o !== 4'b0001) begin
          failures++;
          $display("FAIL single_mid bit=%0d done=%b gnt=%b exp done=0 gnt=0001", i, word_done_o, gnt_o);
        end
      end
    end
    checks++;
    if (cap !== 32'hDEADBEEF || pulses != 32) begin
      failures++;
      $display("FAIL single_word cap=%h pulses=%0d exp cap=deadbeef pulses=32", cap, pulses);
    end
    checks++;
    if (word_done_o !== 1'b1 || gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_done done=%b gnt=%b busy=%b exp done=1 gnt=0000 busy=0", word_done_o, gnt_o, busy_o);
    end
    req_i      = '0;
    data_val_i = '0;
    @(negedge clk);
    checks++;
    if (data_val_o !== 1'b0 || word_done_o !== 1'b0) begin
      failures++;
      $display("FAIL single_after val=%b done=%b exp 0 0", data_val_o, word_done_o);
    end
  endtask

  task automatic test_round_robin();
    int exp_lane [4];
    int n;
    exp_lane = '{0, 1, 3, 0};
    do_reset();
    req_i      = 4'b1011;
    data_val_i = 4'b1111;
    data_i     = 4'b0101;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (gnt_o !== (4'b0001 << exp_lane[g])) begin
        failures++;
        $display("FAIL rr_order grant=%0d gnt=%b exp_lane=%0d", g, gnt_o, exp_lane[g]);
      end
      n = 0;
      while (gnt_o !== 4'b0000 && n < 40) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n != 32) begin
        failures++;
        $display("FAIL rr_len grant=%0d cycles=%0d exp=32", g, n);
      end
      checks++;
      if (word_done_o !== 1'b1 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL rr_bubble grant=%0d done=%b busy=%b exp done=1 busy=0", g, word_done_o, busy_o);
      end
      if (g == 3) begin
        req_i      = '0;
        data_val_i = '0;
      end
      @(negedge clk);
    end
    checks++;
    if (gnt_o !== 4'b0000) begin
      failures++;
      $display("FAIL rr_stop gnt=%b exp=0000", gnt_o);
    end
  endtask

  task automatic test_isolation();
    logic exp_v;
    do_reset();
    req_i  = 4'b0110;
    data_i = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL iso_grant gnt=%b exp=0010", gnt_o);
    end
    for (int i = 0; i < 20; i++) begin
      exp_v      = (i % 3 == 0);
      data_val_i = {1'b0, i[0], exp_v, 1'b0};
      @(negedge clk);
      checks++;
      if (data_val_o !== exp_v || data_o !== 1'b1) begin
        failures++;
        $display("FAIL iso_val cyc=%0d val=%b data=%b exp val=%b data=1", i, data_val_o, data_o, exp_v);
      end
    end
    req_i      = '0;
    data_val_i = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    req_i = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL wd_grant gnt=%b exp=0010", gnt_o);
    end
    for (int i = 0; i < 32; i++) begin
      data_val_i = 4'b0010;
      if (i == 10) req_i = '0;
      @(negedge clk);
      if (i < 31) begin
        checks++;
        if (gnt_o !== 4'b0010 || word_done_o !== 1'b0) begin
          failures++;
          $display("FAIL wd_hold bit=%0d gnt=%b done=%b exp gnt=0010 done=0", i, gnt_o, word_done_o);
        end
      end else begin
        checks++;
        if (gnt_o !== 4'b0000 || word_done_o !== 1'b1) begin
          failures++;
          $display("FAIL wd_done gnt=%b done=%b exp gnt=0000 done=1", gnt_o, word_done_o);
        end
      end
    end
    data_val_i = '0;
  endtask

  task automatic test_timeout();
    int   n;
    logic seen_abort;
    do_reset();
    req_i = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0001) begin
      failures++;
      $display("FAIL to_grant gnt=%b exp=0001", gnt_o);
    end
    for (int i = 0; i < 5; i++) begin
      data_val_i = 4'b0001;
      data_i     = {3'b000, i[0]};
      @(negedge clk);
    end
    data_val_i = '0;
`ifdef SHIFT_ARB_TIMEOUT_EN
    n = 0;
    seen_abort = 1'b0;
    while (abort_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL to_latency cycles=%0d exp=8", n);
    end
    checks++;
    if (gnt_o !== 4'b0000 || word_done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL to_abort gnt=%b done=%b busy=%b exp gnt=0000 done=0 busy=0", gnt_o, word_done_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0010 || abort_o !== 1'b0) begin
      failures++;
      $display("FAIL to_next gnt=%b abort=%b exp gnt=0010 abort=0", gnt_o, abort_o);
    end
`else
    n = 0;
    seen_abort = 1'b0;
    repeat (20) begin
      @(negedge clk);
      n++;
      if (abort_o !== 1'b0) seen_abort = 1'b1;
    end
    checks++;
    if (gnt_o !== 4'b0001 || seen_abort !== 1'b0) begin
      failures++;
      $display("FAIL to_hold cycles=%0d gnt=%b abort_seen=%b exp gnt=0001 abort_seen=0", n, gnt_o, seen_abort);
    end
`endif
    req_i = '0;
  endtask

  task automatic test_reset_midword();
    do_reset();
    req_i      = 4'b0100;
    data_i     = 4'b0100;
    data_val_i = 4'b0100;
    @(negedge clk);
    repeat (32) @(negedge clk);
    checks++;
    if (word_done_o !== 1'b1) begin
      failures++;
      $display("FAIL rm_first_word done=%b exp=1", word_done_o);
    end
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0100 || gnt_idx_o !== 2'd2) begin
      failures++;
      $display("FAIL rm_regrant gnt=%b idx=%0d exp gnt=0100 idx=2", gnt_o, gnt_idx_o);
    end
    repeat (12) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt_o, gnt_idx_o, data_o, data_val_o, word_done_o, abort_o, busy_o} !== 11'b0) begin
      failures++;
      $display("FAIL rm_async got=%b exp=0", {gnt_o, gnt_idx_o, data_o, data_val_o, word_done_o, abort_o, busy_o});
    end
    @(negedge clk);
    rst        = 1'b0;
    req_i      = 4'b1111;
    data_val_i = '0;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0001 || word_done_o !== 1'b0) begin
      failures++;
      $display("FAIL rm_priority gnt=%b done=%b exp gnt=0001 done=0", gnt_o, word_done_o);
    end
    req_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_isolation();
    test_withdraw();
    test_timeout();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

endmodule
